// File: rtl/eth_header_parser_pkg.sv
// Shared constants, types and helpers for the Ethernet header parser.
package eth_header_parser_pkg;

  localparam int ETH_HEADER_BYTES = 14;
  localparam int MAC_W            = 48;
  localparam int ETHTYPE_W        = 16;
  localparam int DATA_W           = 8;
  localparam int CNT_W            = 4;
  localparam int HDR_W            = 2 * MAC_W + ETHTYPE_W;

  // Index of the final header byte. Accepting it without tlast completes a header.
  localparam logic [CNT_W-1:0] LAST_HDR_IDX = CNT_W'(ETH_HEADER_BYTES - 1);

  typedef enum logic {
    ST_HEADER,
    ST_PAYLOAD
  } eth_parse_state_t;

  // Field layout of the header in wire order, first byte at the MSB.
  typedef struct packed {
    logic [MAC_W-1:0]     dest_mac;
    logic [MAC_W-1:0]     src_mac;
    logic [ETHTYPE_W-1:0] eth_type;
  } eth_header_t;

  // Splits the 14-byte header shift register into named fields.
  function automatic eth_header_t unpack_header(input logic [HDR_W-1:0] raw);
    eth_header_t h;
    h = raw;
    return h;
  endfunction

endpackage

// File: rtl/eth_header_parser_if.sv
// Header transaction channel between the parser and its consumer.
//
// Handshake: the master raises valid with dest_mac/src_mac/eth_type and then
// holds valid high and every field constant until a rising clock edge at which
// ready is also high. That edge is the transfer. The master may not make valid
// depend on ready; the slave may drive ready regardless of valid.
interface eth_header_parser_if;
  import eth_header_parser_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [MAC_W-1:0]     dest_mac;
  logic [MAC_W-1:0]     src_mac;
  logic [ETHTYPE_W-1:0] eth_type;

  modport master (
    output valid,
    output dest_mac,
    output src_mac,
    output eth_type,
    input  ready
  );

  modport slave (
    input  valid,
    input  dest_mac,
    input  src_mac,
    input  eth_type,
    output ready
  );

endinterface

// File: rtl/eth_header_parser_skid.sv
// Two-entry skid buffer for the 8-bit payload stream (data + last).
// in_ready comes straight from a flop, so the parser's ready path is
// registered, while the output still moves one beat per clock.
module eth_header_parser_skid
  import eth_header_parser_pkg::*;
(
  input  logic              clk,
  input  logic              sync_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_last;
  logic              in_fire;
  logic              out_free;

  // Input is only stopped once the spare entry holds a beat.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Output register is refilled from the spare entry first, then from the input;
  // a beat arriving while the output is stalled parks in the spare entry.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_last  <= in_last;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_last  <= in_last;
    end
  end

endmodule

// File: rtl/eth_header_parser.sv
// Ethernet RX header parser: pulls dest MAC, src MAC and EtherType off the
// front of each frame into one header transaction and forwards the rest of
// the frame as a payload stream. Frames of 14 bytes or fewer are dropped
// with a one-cycle runt_err pulse.
module eth_header_parser
  import eth_header_parser_pkg::*;
(
  input  logic                 clk,
  input  logic                 sync_rst,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  eth_header_parser_if.master  header_out,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 runt_err,
  output eth_parse_state_t     dbg_state
);

  eth_parse_state_t state;
  eth_parse_state_t next_state;
  logic [CNT_W-1:0] cnt;
  logic [HDR_W-1:0] hdr_shift;
  logic             hdr_valid;
  logic             runt_q;
  logic             s_fire;
  logic             hdr_fire;
  logic             pay_valid;
  logic             pay_ready;
  eth_header_t      hdr_fields;

  assign s_fire   = s_axis_tvalid && s_axis_tready;
  assign hdr_fire = hdr_valid && header_out.ready;

  // Input ready: header bytes wait for the previous header to be taken,
  // payload bytes wait for room in the skid buffer; nothing during reset.
  always_comb begin
    s_axis_tready = 1'b0;
    pay_valid     = 1'b0;
    case (state)
      ST_HEADER:  s_axis_tready = !hdr_valid;
      ST_PAYLOAD: begin
        s_axis_tready = pay_ready;
        pay_valid     = s_axis_tvalid;
      end
      default:    s_axis_tready = 1'b0;
    endcase
    if (sync_rst) begin
      s_axis_tready = 1'b0;
    end
  end

  // Next state: a full header moves to payload, any accepted tlast returns to header.
  always_comb begin
    next_state = state;
    case (state)
      ST_HEADER: begin
        if (s_fire && !s_axis_tlast && (cnt == LAST_HDR_IDX)) begin
          next_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (s_fire && s_axis_tlast) begin
          next_state = ST_HEADER;
        end
      end
      default: next_state = ST_HEADER;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= ST_HEADER;
    end else begin
      state <= next_state;
    end
  end

  // Header capture, byte counter, header valid hold and runt pulse.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt       <= '0;
      hdr_shift <= '0;
      hdr_valid <= 1'b0;
      runt_q    <= 1'b0;
    end else begin
      runt_q <= 1'b0;
      if (hdr_fire) begin
        hdr_valid <= 1'b0;
      end
      if (state == ST_HEADER && s_fire) begin
        hdr_shift <= {hdr_shift[HDR_W-DATA_W-1:0], s_axis_tdata};
        if (s_axis_tlast) begin
          runt_q <= 1'b1;
          cnt    <= '0;
        end else if (cnt == LAST_HDR_IDX) begin
          hdr_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (state == ST_PAYLOAD && s_fire && s_axis_tlast) begin
        cnt <= '0;
      end
    end
  end

  assign hdr_fields          = unpack_header(hdr_shift);
  assign header_out.valid    = hdr_valid;
  assign header_out.dest_mac = hdr_fields.dest_mac;
  assign header_out.src_mac  = hdr_fields.src_mac;
  assign header_out.eth_type = hdr_fields.eth_type;
  assign runt_err            = runt_q;
  assign dbg_state           = state;

  eth_header_parser_skid u_skid (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .in_data   (s_axis_tdata),
    .in_last   (s_axis_tlast),
    .in_valid  (pay_valid),
    .in_ready  (pay_ready),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule
